// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, taken-branch squash and
// data-memory wait freeze. It drives the stage write enables, flushes and stall statistics.
module hazard_stall_ctrl #(
  parameter int REG_W       = 2,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_EX,
  input  logic [REG_W-1:0] Rd_EX,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UsesRs_ID,
  input  logic             UsesRt_ID,
  input  logic             Branch_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic lu, mw;
  logic pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f;

  function automatic logic [CNT_W-1:0] sat_inc_stall(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_wait(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  always_comb begin
    lu = MemRead_EX & ((UsesRs_ID & (Rs_ID == Rd_EX)) | (UsesRt_ID & (Rt_ID == Rd_EX)));
    mw = mem_req_MEM & ~mem_ready;

    pc_w          = 1'b1;
    ifid_w        = 1'b1;
    idex_w        = 1'b1;
    exmem_w       = 1'b1;
    ifid_f        = 1'b0;
    idex_f        = 1'b0;
    state_d       = RUN;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;

    if (state_q == MEM_WAIT && !mem_ready) begin
      // Full freeze; branches are ignored until memory answers.
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_w     = 1'b0;
      exmem_w    = 1'b0;
      state_d    = MEM_WAIT;
      wait_cnt_d = sat_inc_wait(wait_cnt_q);
      if (wait_cnt_q == TIMEOUT) mem_timeout_d = 1'b1;
    end else if (state_q != MEM_WAIT && mw) begin
      pc_w       = 1'b0;
      ifid_w     = 1'b0;
      idex_w     = 1'b0;
      exmem_w    = 1'b0;
      state_d    = MEM_WAIT;
      wait_cnt_d = 8'd1;
    end else if (Branch_EX) begin
      // The load-use consumer sits in ID and is squashed, so no bubble is needed.
      ifid_f = 1'b1;
      idex_f = 1'b1;
    end else if (lu && state_q != LU_STALL) begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      idex_f = 1'b1;
      if (state_q == RUN) state_d = LU_STALL;
    end

    if (!rst_n) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
    end

    stall_cycles_d = pc_w ? stall_cycles_q : sat_inc_stall(stall_cycles_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign PC_Write     = pc_w;
  assign IF_ID_Write  = ifid_w;
  assign ID_EX_Write  = idex_w;
  assign EX_MEM_Write = exmem_w;
  assign IF_ID_Flush  = ifid_f;
  assign ID_EX_Flush  = idex_f;
  assign stall_cycles = stall_cycles_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed hazard scenarios plus random
// traffic against a rule-level reference model; a CNT_W=4 copy checks counter saturation.
module tb_hazard_stall_ctrl;

  localparam int MEM_TIMEOUT = 15;

  logic       clk;
  logic       rst_n;
  logic       MemRead_EX, UsesRs_ID, UsesRt_ID, Branch_EX, mem_req_MEM, mem_ready;
  logic [1:0] Rd_EX, Rs_ID, Rt_ID;

  logic        pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, to;
  logic [15:0] st16;
  logic        pc_w4, ifid_w4, idex_w4, exmem_w4, ifid_f4, idex_f4, to4;
  logic [3:0]  st4;

  hazard_stall_ctrl #(.REG_W(2), .CNT_W(16), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_EX(Branch_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .PC_Write(pc_w), .IF_ID_Write(ifid_w),
    .ID_EX_Write(idex_w), .EX_MEM_Write(exmem_w), .IF_ID_Flush(ifid_f), .ID_EX_Flush(idex_f),
    .stall_cycles(st16), .mem_timeout(to)
  );

  hazard_stall_ctrl #(.REG_W(2), .CNT_W(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut4 (
    .clk(clk), .rst_n(rst_n), .MemRead_EX(MemRead_EX), .Rd_EX(Rd_EX), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID), .Branch_EX(Branch_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .PC_Write(pc_w4), .IF_ID_Write(ifid_w4),
    .ID_EX_Write(idex_w4), .EX_MEM_Write(exmem_w4), .IF_ID_Flush(ifid_f4), .ID_EX_Flush(idex_f4),
    .stall_cycles(st4), .mem_timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: in a memory wait, bubble just inserted, wait length, etc.
  bit m_wait, m_lu, m_to;
  int m_wlen, m_st;
  bit c_lu;
  logic [5:0]  exp_ctrl;
  logic [15:0] exp_st16;
  logic [3:0]  exp_st4;
  logic        exp_to;
  wire  [5:0]  obs_ctrl = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f};

  task automatic drive(input bit rst, input bit mr, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input bit urs, input bit urt, input bit br,
                       input bit req, input bit rdy);
    rst_n = rst; MemRead_EX = mr; Rd_EX = rd; Rs_ID = rs; Rt_ID = rt;
    UsesRs_ID = urs; UsesRt_ID = urt; Branch_EX = br; mem_req_MEM = req; mem_ready = rdy;
    c_lu = mr && ((urs && rs == rd) || (urt && rt == rd));
    // ctrl order: PC, IF_ID, ID_EX, EX_MEM writes, IF_ID flush, ID_EX flush
    if (!rst)                       exp_ctrl = 6'b0000_11;
    else if (m_wait && !rdy)        exp_ctrl = 6'b0000_00;
    else if (!m_wait && req && !rdy) exp_ctrl = 6'b0000_00;
    else if (br)                    exp_ctrl = 6'b1111_11;
    else if (c_lu && !m_lu)         exp_ctrl = 6'b0011_01;
    else                            exp_ctrl = 6'b1111_00;
    exp_st16 = (m_st > 65535) ? 16'hFFFF : 16'(m_st);
    exp_st4  = (m_st > 15) ? 4'hF : 4'(m_st);
    exp_to   = m_to;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_lu = 0; m_wlen = 0; m_to = 0; m_st = 0;
    end else begin
      if (!exp_ctrl[5]) m_st++;
      if (m_wait) begin
        if (!mem_ready) begin
          m_wlen++;
          if (m_wlen > MEM_TIMEOUT) m_to = 1;
        end else begin
          m_wait = 0; m_wlen = 0;
        end
        m_lu = 0;
      end else if (mem_req_MEM && !mem_ready) begin
        m_wait = 1; m_wlen = 1; m_lu = 0;
      end else if (Branch_EX) begin
        m_lu = 0;
      end else begin
        m_lu = c_lu && !m_lu;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2 ? 0 : 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      if (i >= 1) begin
        #1; n_tests++;
        if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
          n_fail++;
          $display("FAIL reset c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                   i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    // lw R1 in EX, consumer reads R1 via Rs; hazard held two cycles, bubble only once
    for (int i = 0; i < 3; i++) begin
      drive(1, i < 2, 2'd1, 2'd1, 2'd2, 1, 0, 0, 0, 1);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL load_use c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  task automatic test_reg_select();
    logic [1:0] rd_t [4] = '{2'd1, 2'd3, 2'd3, 2'd0};
    logic [1:0] rt_t [4] = '{2'd2, 2'd3, 2'd3, 2'd1};
    bit         urs_t[4] = '{0, 0, 0, 1};
    bit         urt_t[4] = '{1, 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, rd_t[i], 2'd1, rt_t[i], urs_t[i], urt_t[i], 0, 0, 1);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL reg_select c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  task automatic test_branch_lu();
    for (int i = 0; i < 3; i++) begin
      drive(1, i < 2, 2'd2, 2'd2, 2'd0, 1, 0, i == 0, 0, 1);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL branch_lu c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  task automatic test_mem_wait(input int low_cycles, input string name);
    for (int i = 0; i <= low_cycles + 1; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, i == 2, i <= low_cycles, i >= low_cycles);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL %s c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 name, i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 9; i++) begin
      drive(i != 5, 0, 0, 0, 0, 0, 0, 0, i < 7, i >= 7);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL reset_mid_wait c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) != 0, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom),
            $urandom_range(0, 3) != 0);
      #1; n_tests++;
      if ({obs_ctrl, st16, st4, to} !== {exp_ctrl, exp_st16, exp_st4, exp_to}) begin
        n_fail++;
        $display("FAIL random c%0d got ctrl=%b st=%0d st4=%0d to=%b want ctrl=%b st=%0d st4=%0d to=%b",
                 i, obs_ctrl, st16, st4, to, exp_ctrl, exp_st16, exp_st4, exp_to);
      end
      tick();
    end
  endtask

  initial begin
    m_wait = 0; m_lu = 0; m_to = 0; m_wlen = 0; m_st = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    test_reset();
    test_load_use();
    test_reg_select();
    test_branch_lu();
    test_mem_wait(4, "mem_wait4");
    test_reset();
    test_mem_wait(16, "timeout16");
    test_reset_mid_wait();
    test_reset();
    test_mem_wait(20, "saturate20");
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
